// File: rtl/ctrl_param_bank_if.sv
// Host-side register bus of the parameter bank: shadow write/readback plus commit handshake.
// The master modport is the host; the slave modport is the bank.
interface ctrl_param_bank_if #(
   parameter int AW = 8
);
   logic          i_wr_en;
   logic [AW-1:0] i_wr_addr;
   logic [15:0]   i_wr_data;
   logic          i_rd_en;
   logic [AW-1:0] i_rd_addr;
   logic [15:0]   o_rd_data;
   logic          o_rd_valid;
   logic          i_commit;
   logic          o_pending;
   logic          o_commit_done;

   modport master (
      output i_wr_en, i_wr_addr, i_wr_data, i_rd_en, i_rd_addr, i_commit,
      input  o_rd_data, o_rd_valid, o_pending, o_commit_done
   );

   modport slave (
      input  i_wr_en, i_wr_addr, i_wr_data, i_rd_en, i_rd_addr, i_commit,
      output o_rd_data, o_rd_valid, o_pending, o_commit_done
   );
endinterface

// File: rtl/ctrl_param_bank.sv
// Double-buffered sequencer parameter bank: host edits a shadow copy, which is promoted to the
// active copy only at a frame boundary so a frame never mixes old and new settings.
module ctrl_param_bank #(
   parameter int N_CH   = 4,
   parameter int N_SLOT = 4,
   localparam int SW    = $clog2(N_SLOT),
   localparam int CW    = $clog2(N_CH),
   localparam int AW    = CW + SW + 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [SW-1:0]        i_slot,
   input  logic                 i_frame_sync,
   ctrl_param_bank_if.slave     host,
   output logic [15:0]          o_ts_time,
   output logic [N_CH*N_CH-1:0] o_pulse_mask,
   output logic [N_CH*8-1:0]    o_pulse_hit,
   output logic [N_CH*8-1:0]    o_pulse_gnd,
   output logic [N_CH*8-1:0]    o_adc_tick,
   output logic [N_CH*8-1:0]    o_adc_ratio,
   output logic [N_CH*8-1:0]    o_dac_level,
   output logic [N_CH*4-1:0]    o_pulse_count,
   output logic [N_CH*16-1:0]   o_pulse_hush,
   output logic [N_CH*CW-1:0]   o_adc_vchn
);
   localparam int N_E = N_CH * N_SLOT;

   typedef struct packed {
      logic [N_CH-1:0] mask;
      logic [7:0]      hit;
      logic [7:0]      gnd;
      logic [3:0]      count;
      logic [15:0]     hush;
      logic [CW-1:0]   vchn;
      logic [7:0]      tick;
      logic [7:0]      ratio;
      logic [7:0]      dac;
   } entry_t;

   typedef enum logic {IDLE, PEND} state_t;

   function automatic entry_t default_entry(input int ch, input int s);
      entry_t e;
      e.mask  = N_CH'(1) << (s % N_CH);
      e.hit   = 8'd40;
      e.gnd   = 8'd40;
      e.count = 4'd4;
      e.hush  = 16'd1000;
      e.vchn  = CW'(s % N_CH);
      e.tick  = 8'd64;
      e.ratio = 8'd14;
      e.dac   = 8'd120;
      if (ch == N_CH - 1 && s == N_SLOT - 1) begin
         e.hit   = 8'd20;
         e.gnd   = 8'd60;
         e.count = 4'd1;
      end
      return e;
   endfunction

   entry_t      sh_q [N_E];
   entry_t      sh_d [N_E];
   entry_t      act_q [N_E];
   entry_t      act_d [N_E];
   logic [15:0] ts_sh_q [N_SLOT];
   logic [15:0] ts_sh_d [N_SLOT];
   logic [15:0] ts_act_q [N_SLOT];
   logic [15:0] ts_act_d [N_SLOT];
   entry_t      out_q [N_CH];
   entry_t      out_d [N_CH];
   logic [15:0] out_ts_q, out_ts_d;
   state_t      state_q, state_d;
   logic        pending_q, pending_d;
   logic        done_q, done_d;
   logic [15:0] rd_data_q, rd_data_d;
   logic        rd_valid_q, rd_valid_d;
   logic        copy;
   logic [15:0] rd_val;

   // Address layout is {ch, slot, field}; {ch, slot} doubles as the entry index.
   logic [CW-1:0]    wr_ch, rd_ch;
   logic [SW-1:0]    wr_slot, rd_slot;
   logic [3:0]       wr_fld, rd_fld;
   logic [CW+SW-1:0] wr_e, rd_e;
   logic             wr_ok, rd_ok;

   assign wr_ch   = host.i_wr_addr[AW-1 -: CW];
   assign wr_slot = host.i_wr_addr[4 +: SW];
   assign wr_fld  = host.i_wr_addr[3:0];
   assign wr_e    = {wr_ch, wr_slot};
   assign wr_ok   = host.i_wr_en && (int'(wr_ch) < N_CH);
   assign rd_ch   = host.i_rd_addr[AW-1 -: CW];
   assign rd_slot = host.i_rd_addr[4 +: SW];
   assign rd_fld  = host.i_rd_addr[3:0];
   assign rd_e    = {rd_ch, rd_slot};
   assign rd_ok   = int'(rd_ch) < N_CH;

   always_comb begin
      state_d = state_q;
      copy    = 1'b0;
      case (state_q)
         IDLE: begin
            if (host.i_commit) begin
               if (i_frame_sync) copy = 1'b1;
               else              state_d = PEND;
            end
         end
         PEND: begin
            if (i_frame_sync) begin
               copy    = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      pending_d = (state_d == PEND);
      done_d    = copy;
   end

   // The copy samples the pre-edge shadow, so a same-cycle host write lands in shadow only.
   always_comb begin
      sh_d     = sh_q;
      ts_sh_d  = ts_sh_q;
      act_d    = copy ? sh_q : act_q;
      ts_act_d = copy ? ts_sh_q : ts_act_q;
      if (wr_ok) begin
         case (wr_fld)
            4'd0: ts_sh_d[wr_slot]  = host.i_wr_data;
            4'd1: sh_d[wr_e].mask  = host.i_wr_data[N_CH-1:0];
            4'd2: sh_d[wr_e].hit   = host.i_wr_data[7:0];
            4'd3: sh_d[wr_e].gnd   = host.i_wr_data[7:0];
            4'd4: sh_d[wr_e].count = host.i_wr_data[3:0];
            4'd5: sh_d[wr_e].hush  = host.i_wr_data;
            4'd6: sh_d[wr_e].vchn  = host.i_wr_data[CW-1:0];
            4'd7: sh_d[wr_e].tick  = host.i_wr_data[7:0];
            4'd8: sh_d[wr_e].ratio = host.i_wr_data[7:0];
            4'd9: sh_d[wr_e].dac   = host.i_wr_data[7:0];
            default: ;
         endcase
      end
   end

   always_comb begin
      rd_val = '0;
      if (rd_ok) begin
         case (rd_fld)
            4'd0: rd_val = ts_sh_q[rd_slot];
            4'd1: rd_val = 16'(sh_q[rd_e].mask);
            4'd2: rd_val = 16'(sh_q[rd_e].hit);
            4'd3: rd_val = 16'(sh_q[rd_e].gnd);
            4'd4: rd_val = 16'(sh_q[rd_e].count);
            4'd5: rd_val = sh_q[rd_e].hush;
            4'd6: rd_val = 16'(sh_q[rd_e].vchn);
            4'd7: rd_val = 16'(sh_q[rd_e].tick);
            4'd8: rd_val = 16'(sh_q[rd_e].ratio);
            4'd9: rd_val = 16'(sh_q[rd_e].dac);
            default: rd_val = '0;
         endcase
      end
      rd_data_d  = host.i_rd_en ? rd_val : rd_data_q;
      rd_valid_d = host.i_rd_en;
   end

   always_comb begin
      for (int k = 0; k < N_CH; k++) out_d[k] = act_q[{CW'(k), i_slot}];
      out_ts_d = ts_act_q[i_slot];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_E; i++) begin
            sh_q[i]  <= default_entry(i / N_SLOT, i % N_SLOT);
            act_q[i] <= default_entry(i / N_SLOT, i % N_SLOT);
         end
         for (int s = 0; s < N_SLOT; s++) begin
            ts_sh_q[s]  <= 16'd3600;
            ts_act_q[s] <= 16'd3600;
         end
         for (int k = 0; k < N_CH; k++) out_q[k] <= default_entry(k, 0);
         out_ts_q   <= 16'd3600;
         state_q    <= IDLE;
         pending_q  <= 1'b0;
         done_q     <= 1'b0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         sh_q       <= sh_d;
         act_q      <= act_d;
         ts_sh_q    <= ts_sh_d;
         ts_act_q   <= ts_act_d;
         out_q      <= out_d;
         out_ts_q   <= out_ts_d;
         state_q    <= state_d;
         pending_q  <= pending_d;
         done_q     <= done_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   assign host.o_rd_data     = rd_data_q;
   assign host.o_rd_valid    = rd_valid_q;
   assign host.o_pending     = pending_q;
   assign host.o_commit_done = done_q;
   assign o_ts_time          = out_ts_q;

   for (genvar gi = 0; gi < N_CH; gi++) begin : g_out
      assign o_pulse_mask[gi*N_CH +: N_CH] = out_q[gi].mask;
      assign o_pulse_hit[gi*8 +: 8]        = out_q[gi].hit;
      assign o_pulse_gnd[gi*8 +: 8]        = out_q[gi].gnd;
      assign o_pulse_count[gi*4 +: 4]      = out_q[gi].count;
      assign o_pulse_hush[gi*16 +: 16]     = out_q[gi].hush;
      assign o_adc_vchn[gi*CW +: CW]       = out_q[gi].vchn;
      assign o_adc_tick[gi*8 +: 8]         = out_q[gi].tick;
      assign o_adc_ratio[gi*8 +: 8]        = out_q[gi].ratio;
      assign o_dac_level[gi*8 +: 8]        = out_q[gi].dac;
   end
endmodule

// File: tb/tb_ctrl_param_bank.sv
// Bench for ctrl_param_bank: directed scenarios with literal expectations, then random traffic,
// all checked every cycle against a field-table model of the two banks.
module tb_ctrl_param_bank;
   localparam int N_CH = 4, N_SLOT = 4, SW = 2, CW = 2, AW = CW + SW + 4;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic [SW-1:0]        slot = '0;
   logic                 frame_sync = 1'b0;
   logic [15:0]          o_ts_time;
   logic [N_CH*N_CH-1:0] o_pulse_mask;
   logic [N_CH*8-1:0]    o_pulse_hit, o_pulse_gnd, o_adc_tick, o_adc_ratio, o_dac_level;
   logic [N_CH*4-1:0]    o_pulse_count;
   logic [N_CH*16-1:0]   o_pulse_hush;
   logic [N_CH*CW-1:0]   o_adc_vchn;

   ctrl_param_bank_if #(.AW(AW)) host_if ();

   ctrl_param_bank #(.N_CH(N_CH), .N_SLOT(N_SLOT)) dut (
      .clk(clk), .rst_n(rst_n), .i_slot(slot), .i_frame_sync(frame_sync), .host(host_if.slave),
      .o_ts_time(o_ts_time), .o_pulse_mask(o_pulse_mask), .o_pulse_hit(o_pulse_hit),
      .o_pulse_gnd(o_pulse_gnd), .o_adc_tick(o_adc_tick), .o_adc_ratio(o_adc_ratio),
      .o_dac_level(o_dac_level), .o_pulse_count(o_pulse_count), .o_pulse_hush(o_pulse_hush),
      .o_adc_vchn(o_adc_vchn)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_bad++;
         if (n_bad <= 40) $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model: per-field integer tables ----------------
   int m_sh  [N_CH][N_SLOT][10];
   int m_act [N_CH][N_SLOT][10];
   int m_ts_sh [N_SLOT];
   int m_ts_act [N_SLOT];
   bit m_pend;
   int e_out [N_CH][10];
   int e_ts, e_rd_data;
   bit e_rd_valid, e_done, e_pend;

   function automatic int fw(input int f);
      case (f)
         0, 5: return 16;
         1: return N_CH;
         4: return 4;
         6: return CW;
         default: return 8;
      endcase
   endfunction

   function automatic int dflt(input int ch, input int s, input int f);
      bit last = (ch == N_CH - 1) && (s == N_SLOT - 1);
      case (f)
         0: return 3600;
         1: return 1 << (s % N_CH);
         2: return last ? 20 : 40;
         3: return last ? 60 : 40;
         4: return last ? 1 : 4;
         5: return 1000;
         6: return s % N_CH;
         7: return 64;
         8: return 14;
         9: return 120;
         default: return 0;
      endcase
   endfunction

   function automatic int m_read(input int addr);
      int f = addr % 16;
      int s = (addr / 16) % N_SLOT;
      int ch = addr / (16 * N_SLOT);
      if (ch >= N_CH || f > 9) return 0;
      if (f == 0) return m_ts_sh[s];
      return m_sh[ch][s][f];
   endfunction

   task automatic m_reset();
      for (int c = 0; c < N_CH; c++)
         for (int s = 0; s < N_SLOT; s++)
            for (int f = 0; f < 10; f++) begin
               m_sh[c][s][f]  = dflt(c, s, f);
               m_act[c][s][f] = dflt(c, s, f);
            end
      for (int s = 0; s < N_SLOT; s++) begin
         m_ts_sh[s]  = 3600;
         m_ts_act[s] = 3600;
      end
      for (int c = 0; c < N_CH; c++)
         for (int f = 0; f < 10; f++) e_out[c][f] = dflt(c, 0, f);
      e_ts = 3600; e_rd_data = 0; e_rd_valid = 0; e_done = 0; e_pend = 0; m_pend = 0;
   endtask

   task automatic m_step();
      int a, f, s, ch;
      bit cp;
      if (host_if.i_rd_en) begin
         e_rd_data  = m_read(int'(host_if.i_rd_addr));
         e_rd_valid = 1;
      end else e_rd_valid = 0;
      for (int c = 0; c < N_CH; c++)
         for (int k = 1; k < 10; k++) e_out[c][k] = m_act[c][slot][k];
      e_ts = m_ts_act[slot];
      cp = frame_sync && (m_pend || host_if.i_commit);
      if (cp) begin
         m_act    = m_sh;
         m_ts_act = m_ts_sh;
      end
      e_done = cp;
      m_pend = cp ? 1'b0 : (m_pend || host_if.i_commit);
      e_pend = m_pend;
      if (host_if.i_wr_en) begin
         a = int'(host_if.i_wr_addr);
         f = a % 16; s = (a / 16) % N_SLOT; ch = a / (16 * N_SLOT);
         if (ch < N_CH) begin
            if (f == 0) m_ts_sh[s] = int'(host_if.i_wr_data);
            else if (f <= 9) m_sh[ch][s][f] = int'(host_if.i_wr_data) & ((1 << fw(f)) - 1);
         end
      end
   endtask

   initial m_reset();

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) m_reset();
      else        m_step();
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      chk("ts_time", int'(o_ts_time), e_ts);
      for (int k = 0; k < N_CH; k++) begin
         chk($sformatf("mask[%0d]", k),  int'(o_pulse_mask[k*N_CH +: N_CH]), e_out[k][1]);
         chk($sformatf("hit[%0d]", k),   int'(o_pulse_hit[k*8 +: 8]),        e_out[k][2]);
         chk($sformatf("gnd[%0d]", k),   int'(o_pulse_gnd[k*8 +: 8]),        e_out[k][3]);
         chk($sformatf("count[%0d]", k), int'(o_pulse_count[k*4 +: 4]),      e_out[k][4]);
         chk($sformatf("hush[%0d]", k),  int'(o_pulse_hush[k*16 +: 16]),     e_out[k][5]);
         chk($sformatf("vchn[%0d]", k),  int'(o_adc_vchn[k*CW +: CW]),       e_out[k][6]);
         chk($sformatf("tick[%0d]", k),  int'(o_adc_tick[k*8 +: 8]),         e_out[k][7]);
         chk($sformatf("ratio[%0d]", k), int'(o_adc_ratio[k*8 +: 8]),        e_out[k][8]);
         chk($sformatf("dac[%0d]", k),   int'(o_dac_level[k*8 +: 8]),        e_out[k][9]);
      end
      chk("pending", int'(host_if.o_pending), int'(e_pend));
      chk("commit_done", int'(host_if.o_commit_done), int'(e_done));
      chk("rd_valid", int'(host_if.o_rd_valid), int'(e_rd_valid));
      if (e_rd_valid || !rst_n) chk("rd_data", int'(host_if.o_rd_data), e_rd_data);
   end

   // ---------------- stimulus ----------------
   function automatic logic [AW-1:0] mk(input int ch, input int s, input int f);
      return AW'(ch * 16 * N_SLOT + s * 16 + f);
   endfunction

   task automatic idle_bus();
      host_if.i_wr_en = 0; host_if.i_rd_en = 0; host_if.i_commit = 0; frame_sync = 0;
   endtask

   task automatic cyc();
      @(negedge clk);
   endtask

   initial begin
      host_if.i_wr_addr = '0; host_if.i_wr_data = '0; host_if.i_rd_addr = '0;
      idle_bus();
      repeat (3) cyc();
      rst_n = 1'b1;
      // Reset defaults at slot 0
      chk("t1_ts", int'(o_ts_time), 3600);
      chk("t1_hit", int'(o_pulse_hit), 32'h28282828);
      chk("t1_dac", int'(o_dac_level), 32'h78787878);
      chk("t1_pend", int'(host_if.o_pending), 0);
      // Exception entry and per-slot mask
      slot = 2'd3; cyc();
      chk("t2_hit3", int'(o_pulse_hit[31:24]), 20);
      chk("t2_gnd3", int'(o_pulse_gnd[31:24]), 60);
      chk("t2_cnt3", int'(o_pulse_count[15:12]), 1);
      slot = 2'd1; cyc();
      chk("t2_mask0", int'(o_pulse_mask[3:0]), 2);
      // Shadow isolation
      host_if.i_wr_en = 1; host_if.i_wr_addr = mk(1, 2, 9); host_if.i_wr_data = 16'h0055; cyc();
      host_if.i_wr_en = 0; host_if.i_rd_en = 1; host_if.i_rd_addr = mk(1, 2, 9); cyc();
      host_if.i_rd_en = 0;
      chk("t3_rd", int'(host_if.o_rd_data), 16'h55);
      chk("t3_rdv", int'(host_if.o_rd_valid), 1);
      slot = 2'd2; cyc();
      chk("t3_dac1", int'(o_dac_level[15:8]), 120);
      // Commit at frame boundary
      host_if.i_commit = 1; cyc();
      host_if.i_commit = 0;
      chk("t4_pend", int'(host_if.o_pending), 1);
      repeat (4) cyc();
      frame_sync = 1; cyc();
      frame_sync = 0;
      chk("t4_done", int'(host_if.o_commit_done), 1);
      chk("t4_pend0", int'(host_if.o_pending), 0);
      cyc();
      chk("t4_dac1", int'(o_dac_level[15:8]), 16'h55);
      // Commit+sync same cycle with a write in that cycle
      host_if.i_commit = 1; frame_sync = 1;
      host_if.i_wr_en = 1; host_if.i_wr_addr = mk(0, 0, 2); host_if.i_wr_data = 16'd7;
      slot = 2'd0; cyc();
      idle_bus();
      chk("t5_done", int'(host_if.o_commit_done), 1);
      cyc();
      chk("t5_hit0", int'(o_pulse_hit[7:0]), 40);
      host_if.i_rd_en = 1; host_if.i_rd_addr = mk(0, 0, 2); cyc();
      host_if.i_rd_en = 0;
      chk("t5_sh", int'(host_if.o_rd_data), 7);
      host_if.i_wr_en = 1; host_if.i_wr_addr = mk(2, 1, 12); host_if.i_wr_data = 16'hFFFF; cyc();
      host_if.i_wr_en = 0; host_if.i_rd_en = 1; host_if.i_rd_addr = mk(2, 1, 12); cyc();
      host_if.i_rd_en = 0;
      chk("t5_f12", int'(host_if.o_rd_data), 0);
      // Reset while a commit is pending
      host_if.i_commit = 1; cyc();
      host_if.i_commit = 0;
      chk("t6_pend", int'(host_if.o_pending), 1);
      #2 rst_n = 1'b0;
      cyc(); cyc();
      rst_n = 1'b1;
      slot = 2'd2; frame_sync = 1; cyc();
      frame_sync = 0;
      chk("t6_done", int'(host_if.o_commit_done), 0);
      chk("t6_pend0", int'(host_if.o_pending), 0);
      chk("t6_dac1", int'(o_dac_level[15:8]), 120);
      host_if.i_rd_en = 1; host_if.i_rd_addr = mk(0, 0, 2); cyc();
      host_if.i_rd_en = 0;
      chk("t6_sh", int'(host_if.o_rd_data), 40);
      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         slot              = SW'($urandom);
         frame_sync        = ($urandom_range(0, 5) == 0);
         host_if.i_commit  = ($urandom_range(0, 9) == 0);
         host_if.i_wr_en   = ($urandom_range(0, 2) == 0);
         host_if.i_wr_addr = AW'($urandom);
         host_if.i_wr_data = 16'($urandom);
         host_if.i_rd_en   = ($urandom_range(0, 1) == 0);
         host_if.i_rd_addr = ($urandom_range(0, 3) == 0) ? host_if.i_wr_addr : AW'($urandom);
         if ($urandom_range(0, 599) == 0) begin
            #2 rst_n = 1'b0;
            cyc();
            rst_n = 1'b1;
         end else cyc();
      end
      idle_bus();
      cyc();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
